// File: rtl/usb_phy_rx.sv
// Full-speed USB receive PHY: line-state decode, SYNC detection, NRZI decode,
// bit unstuffing, byte assembly and a small output FIFO toward the link layer.
module usb_phy_rx #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dp,
    input  logic       dm,
    input  logic       bit_en,
    input  logic       tx_active,
    output logic       rx_lp_sop,
    output logic       rx_lp_eop,
    output logic       rx_lp_valid,
    input  logic       rx_lp_ready,
    output logic [7:0] rx_lp_data,
    output logic       rx_err
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = 10;

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_ABORT, S_EOP} state_e;
    typedef enum logic [1:0] {L_SE0, L_J, L_K} line_e;

    state_e           state_q, state_d;
    line_e            line_c;
    logic             bit_c;

    line_e            prev_q, prev_d;
    logic             last_k_q, last_k_d;
    logic [2:0]       ones_q, ones_d;
    logic [2:0]       bcnt_q, bcnt_d;
    logic [6:0]       shift_q, shift_d;
    logic             hold_v_q, hold_v_d;
    logic             hold_sop_q, hold_sop_d;
    logic [7:0]       hold_data_q, hold_data_d;
    logic             any_byte_q, any_byte_d;

    logic             push_en_c, push_sop_c, push_eop_c, err_ev_c;
    logic [7:0]       push_data_c;

    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rx_err_q, rx_err_d;
    logic             full_c, pop_c, push_ok_c, drop_c;

    // Line-state decode; dp=dm=1 is treated as SE0, NRZI bit is 1 when the state repeats
    always_comb begin
        line_c = L_SE0;
        if (dp && !dm)      line_c = L_J;
        else if (!dp && dm) line_c = L_K;
        bit_c = (line_c == prev_q);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; transmit activity forces IDLE regardless of bit strobe
    always_comb begin
        state_d = state_q;
        if (tx_active) begin
            state_d = S_IDLE;
        end else if (bit_en) begin
            case (state_q)
                S_IDLE:  if (line_c == L_K) state_d = S_SYNC;
                S_SYNC: begin
                    if (line_c == L_SE0)                  state_d = S_IDLE;
                    else if (line_c == L_K && last_k_q)   state_d = S_DATA;
                end
                S_DATA: begin
                    if (line_c == L_SE0)                  state_d = S_EOP;
                    else if (ones_q == 3'd6 && bit_c)     state_d = S_ABORT;
                end
                S_ABORT: if (line_c == L_SE0) state_d = S_EOP;
                S_EOP: begin
                    if (line_c == L_J)      state_d = S_IDLE;
                    else if (line_c == L_K) state_d = S_SYNC;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output/datapath logic: unstuffing, byte assembly, holding register and FIFO pushes
    always_comb begin
        prev_d      = prev_q;
        last_k_d    = last_k_q;
        ones_d      = ones_q;
        bcnt_d      = bcnt_q;
        shift_d     = shift_q;
        hold_v_d    = hold_v_q;
        hold_sop_d  = hold_sop_q;
        hold_data_d = hold_data_q;
        any_byte_d  = any_byte_q;
        push_en_c   = 1'b0;
        push_sop_c  = hold_sop_q;
        push_eop_c  = 1'b0;
        push_data_c = hold_data_q;
        err_ev_c    = 1'b0;

        if (tx_active) begin
            hold_v_d   = 1'b0;
            bcnt_d     = 3'd0;
            ones_d     = 3'd0;
            last_k_d   = 1'b0;
            any_byte_d = 1'b0;
        end else if (bit_en) begin
            case (state_q)
                S_IDLE, S_EOP: last_k_d = (line_c == L_K);
                S_SYNC: begin
                    last_k_d = (line_c == L_K);
                    if (line_c == L_K && last_k_q) begin
                        prev_d     = L_K;
                        ones_d     = 3'd0;
                        bcnt_d     = 3'd0;
                        hold_v_d   = 1'b0;
                        any_byte_d = 1'b0;
                    end
                end
                S_DATA: begin
                    if (line_c == L_SE0) begin
                        // End of packet: flush held byte as last, flag a partial byte
                        push_en_c  = hold_v_q;
                        push_eop_c = 1'b1;
                        hold_v_d   = 1'b0;
                        err_ev_c   = (bcnt_q != 3'd0);
                        bcnt_d     = 3'd0;
                        ones_d     = 3'd0;
                    end else begin
                        prev_d = line_c;
                        if (ones_q == 3'd6) begin
                            ones_d = 3'd0;
                            bcnt_d = bcnt_q;
                            if (bit_c) begin
                                // Seventh consecutive 1: stuffing violation
                                err_ev_c   = 1'b1;
                                push_en_c  = hold_v_q;
                                push_eop_c = 1'b1;
                                hold_v_d   = 1'b0;
                                bcnt_d     = 3'd0;
                            end
                        end else begin
                            shift_d = {bit_c, shift_q[6:1]};
                            ones_d  = bit_c ? (ones_q + 3'd1) : 3'd0;
                            bcnt_d  = bcnt_q + 3'd1;
                            if (bcnt_q == 3'd7) begin
                                // Completed byte enters holding; older held byte goes out
                                push_en_c   = hold_v_q;
                                push_eop_c  = 1'b0;
                                hold_data_d = {bit_c, shift_q};
                                hold_sop_d  = !any_byte_q;
                                hold_v_d    = 1'b1;
                                any_byte_d  = 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Receiver datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q      <= L_K;
            last_k_q    <= 1'b0;
            ones_q      <= 3'd0;
            bcnt_q      <= 3'd0;
            shift_q     <= 7'd0;
            hold_v_q    <= 1'b0;
            hold_sop_q  <= 1'b0;
            hold_data_q <= 8'd0;
            any_byte_q  <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            last_k_q    <= last_k_d;
            ones_q      <= ones_d;
            bcnt_q      <= bcnt_d;
            shift_q     <= shift_d;
            hold_v_q    <= hold_v_d;
            hold_sop_q  <= hold_sop_d;
            hold_data_q <= hold_data_d;
            any_byte_q  <= any_byte_d;
        end
    end

    // FIFO control: a pop frees room for a simultaneous push when full
    always_comb begin
        full_c    = (cnt_q == CNT_W'(FIFO_DEPTH));
        pop_c     = (cnt_q != '0) && rx_lp_ready;
        push_ok_c = push_en_c && (!full_c || pop_c);
        drop_c    = push_en_c && full_c && !pop_c;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (push_ok_c) begin
            mem_d[wr_ptr_q] = {push_sop_c, push_eop_c, push_data_c};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        cnt_d    = cnt_q + CNT_W'(push_ok_c) - CNT_W'(pop_c);
        rx_err_d = err_ev_c || drop_c;
    end

    // FIFO storage and error pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            rx_err_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            rx_err_q <= rx_err_d;
        end
    end

    assign rx_lp_valid = (cnt_q != '0);
    assign rx_lp_sop   = mem_q[rd_ptr_q][9];
    assign rx_lp_eop   = mem_q[rd_ptr_q][8];
    assign rx_lp_data  = mem_q[rd_ptr_q][7:0];
    assign rx_err      = rx_err_q;

endmodule
